// File: rtl/red_pitaya_iq_sweep_sequencer.sv
// ============================================================================
// red_pitaya_iq_sweep_sequencer
//
// Purpose:
//   Steps the IQ demodulator reference frequency through an N-point sweep.
//   For every point the block:
//     1. drives the frequency word and pulses a phase reset to the generator,
//     2. waits a settling time so the demod pipeline flushes old samples,
//     3. integrates the demod I/Q outputs for a programmed number of cycles,
//     4. presents the two sums on a valid/ready result port.
//   The block sits between the register bank (config, start) and the
//   demod/fgen pair.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   start_i               1-cycle pulse: latch config and start the sweep
//   abort_i               stop the sweep and return to idle (no done pulse)
//   f_start_i, f_step_i   first frequency word and per-point increment
//   n_points_i            number of points in the sweep
//   settle_cycles_i       wait after each frequency change (minimum 3)
//   avg_cycles_i          samples integrated per point (0 behaves as 1)
//   demod_i_i, demod_q_i  signed demodulator outputs
//   freq_o, phase_rst_o   frequency word and phase-reset pulse to the fgen
//   busy_o                high whenever a sweep is in progress
//   res_valid_o/ready_i   result handshake
//   res_i_o, res_q_o      signed I/Q sums of the current point
//   res_idx_o             index of the current point
//   done_o                1-cycle pulse after the last result is accepted
// ============================================================================
module red_pitaya_iq_sweep_sequencer #(
  parameter int OUTBITS   = 18,
  parameter int PHASEBITS = 32,
  parameter int AVGBITS   = 16,
  parameter int ACCBITS   = 34,
  parameter int CNTBITS   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [PHASEBITS-1:0] f_start_i,
  input  logic [PHASEBITS-1:0] f_step_i,
  input  logic [CNTBITS-1:0]   n_points_i,
  input  logic [CNTBITS-1:0]   settle_cycles_i,
  input  logic [AVGBITS-1:0]   avg_cycles_i,
  input  logic [OUTBITS-1:0]   demod_i_i,
  input  logic [OUTBITS-1:0]   demod_q_i,
  output logic [PHASEBITS-1:0] freq_o,
  output logic                 phase_rst_o,
  output logic                 busy_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ACCBITS-1:0]   res_i_o,
  output logic [ACCBITS-1:0]   res_q_o,
  output logic [CNTBITS-1:0]   res_idx_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_INTEG,
    ST_OUTPUT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Latched configuration, so register-bank writes mid-sweep have no effect
  logic [CNTBITS-1:0]   r_nPoints;
  logic [CNTBITS-1:0]   r_settle;
  logic [AVGBITS-1:0]   r_avg;
  logic [PHASEBITS-1:0] r_fStep;

  logic [CNTBITS-1:0]   r_idx;
  logic [PHASEBITS-1:0] r_freq;
  logic [CNTBITS-1:0]   r_settleCnt;
  logic [AVGBITS-1:0]   r_avgCnt;
  logic [ACCBITS-1:0]   r_accI;
  logic [ACCBITS-1:0]   r_accQ;
  logic                 r_done;

  logic                 w_lastPoint;
  logic [CNTBITS-1:0]   w_settleLoad;
  logic [AVGBITS-1:0]   w_avgLoad;
  logic [ACCBITS-1:0]   w_extI;
  logic [ACCBITS-1:0]   w_extQ;
  logic                 w_phaseRst;
  logic                 w_busy;
  logic                 w_valid;

  assign w_lastPoint = (r_idx == r_nPoints - CNTBITS'(1));

  // Counters run down to zero, so they are loaded with (length - 1).
  // Settling is floored at 3 cycles to cover the demod's 2-cycle pipeline,
  // guaranteeing no sample from the previous frequency is integrated.
  assign w_settleLoad = (r_settle < CNTBITS'(3)) ? CNTBITS'(2)
                                                 : r_settle - CNTBITS'(1);
  assign w_avgLoad    = (r_avg == '0) ? '0 : r_avg - AVGBITS'(1);

  // ACCBITS >= OUTBITS + AVGBITS, so the sums cannot overflow
  assign w_extI = {{(ACCBITS-OUTBITS){demod_i_i[OUTBITS-1]}}, demod_i_i};
  assign w_extQ = {{(ACCBITS-OUTBITS){demod_q_i[OUTBITS-1]}}, demod_q_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and state-decoded outputs; abort wins over everything,
  // including a result accepted in the same cycle
  always_comb begin
    w_nextState = r_state;
    w_phaseRst  = 1'b0;
    w_busy      = 1'b1;
    w_valid     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start_i && (n_points_i != '0)) begin
          w_nextState = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_phaseRst  = 1'b1;
        w_nextState = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settleCnt == '0) begin
          w_nextState = ST_INTEG;
        end
      end
      ST_INTEG: begin
        if (r_avgCnt == '0) begin
          w_nextState = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        w_valid = 1'b1;
        if (res_ready_i) begin
          w_nextState = w_lastPoint ? ST_IDLE : ST_SETUP;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    if (abort_i) begin
      w_nextState = ST_IDLE;
    end
  end

  // Datapath: config latch, point index/frequency, counters, accumulators.
  // On abort every register simply holds; the FSM alone returns to idle, so
  // freq_o keeps its last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_nPoints   <= '0;
      r_settle    <= '0;
      r_avg       <= '0;
      r_fStep     <= '0;
      r_idx       <= '0;
      r_freq      <= '0;
      r_settleCnt <= '0;
      r_avgCnt    <= '0;
      r_accI      <= '0;
      r_accQ      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!abort_i) begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_nPoints <= n_points_i;
              r_settle  <= settle_cycles_i;
              r_avg     <= avg_cycles_i;
              r_fStep   <= f_step_i;
              r_idx     <= '0;
              r_freq    <= f_start_i;
              // An empty sweep finishes immediately
              if (n_points_i == '0) begin
                r_done <= 1'b1;
              end
            end
          end
          ST_SETUP: begin
            r_accI      <= '0;
            r_accQ      <= '0;
            r_settleCnt <= w_settleLoad;
            r_avgCnt    <= w_avgLoad;
          end
          ST_SETTLE: begin
            if (r_settleCnt != '0) begin
              r_settleCnt <= r_settleCnt - CNTBITS'(1);
            end
          end
          ST_INTEG: begin
            r_accI <= r_accI + w_extI;
            r_accQ <= r_accQ + w_extQ;
            if (r_avgCnt != '0) begin
              r_avgCnt <= r_avgCnt - AVGBITS'(1);
            end
          end
          ST_OUTPUT: begin
            if (res_ready_i) begin
              if (w_lastPoint) begin
                r_done <= 1'b1;
              end else begin
                r_idx  <= r_idx + CNTBITS'(1);
                r_freq <= r_freq + r_fStep;
              end
            end
          end
          default: begin
            r_done <= 1'b0;
          end
        endcase
      end
    end
  end

  assign freq_o      = r_freq;
  assign phase_rst_o = w_phaseRst;
  assign busy_o      = w_busy;
  assign res_valid_o = w_valid;
  assign res_i_o     = r_accI;
  assign res_q_o     = r_accQ;
  assign res_idx_o   = r_idx;
  assign done_o      = r_done;

endmodule

// File: tb/tb_red_pitaya_iq_sweep_sequencer.sv
// ============================================================================
// tb_red_pitaya_iq_sweep_sequencer
//
// Purpose:
//   Self-checking bench for the IQ sweep sequencer. Each sweep pushes its
//   expected results (index, frequency, I/Q sums, latency from phase reset)
//   into a queue; a monitor on the falling clock edge pops and compares on
//   every accepted result, and also checks done/busy/reset behaviour.
//   Demod inputs are held constant per sweep so each expected sum is simply
//   sample * number_of_samples.
//
// Ports: none (top-level bench).
// ============================================================================
module tb_red_pitaya_iq_sweep_sequencer;

  localparam int OUTBITS   = 18;
  localparam int PHASEBITS = 32;
  localparam int AVGBITS   = 16;
  localparam int ACCBITS   = 34;
  localparam int CNTBITS   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 startPulse = 1'b0;
  logic                 abortPulse = 1'b0;
  logic [PHASEBITS-1:0] fStart = '0;
  logic [PHASEBITS-1:0] fStep = '0;
  logic [CNTBITS-1:0]   nPoints = '0;
  logic [CNTBITS-1:0]   settleCycles = '0;
  logic [AVGBITS-1:0]   avgCycles = '0;
  logic [OUTBITS-1:0]   demodI = '0;
  logic [OUTBITS-1:0]   demodQ = '0;
  logic                 resReady = 1'b0;

  logic [PHASEBITS-1:0] freqOut;
  logic                 phaseRst;
  logic                 busy;
  logic                 resValid;
  logic [ACCBITS-1:0]   resI;
  logic [ACCBITS-1:0]   resQ;
  logic [CNTBITS-1:0]   resIdx;
  logic                 done;

  red_pitaya_iq_sweep_sequencer #(
    .OUTBITS(OUTBITS), .PHASEBITS(PHASEBITS), .AVGBITS(AVGBITS),
    .ACCBITS(ACCBITS), .CNTBITS(CNTBITS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(startPulse),
    .abort_i(abortPulse),
    .f_start_i(fStart),
    .f_step_i(fStep),
    .n_points_i(nPoints),
    .settle_cycles_i(settleCycles),
    .avg_cycles_i(avgCycles),
    .demod_i_i(demodI),
    .demod_q_i(demodQ),
    .freq_o(freqOut),
    .phase_rst_o(phaseRst),
    .busy_o(busy),
    .res_valid_o(resValid),
    .res_ready_i(resReady),
    .res_i_o(resI),
    .res_q_o(resQ),
    .res_idx_o(resIdx),
    .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint idx;
    longint freq;
    longint sumI;
    longint sumQ;
    bit     last;
    longint lat;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int failures = 0;

  // Monitor bookkeeping
  int cyc = 0;
  int zeroAt = -1;
  int doneAt = -1;
  int gapAt = -1;
  int idleAt = -1;
  int lastRstCyc = 0;
  int phaseCount = 0;
  int doneCount = 0;
  int acceptCount = 0;
  int stallCount = 0;
  bit prevValid = 1'b0;
  bit prevAccept = 1'b0;
  logic [ACCBITS-1:0]   savedI = '0;
  logic [ACCBITS-1:0]   savedQ = '0;
  logic [CNTBITS-1:0]   savedIdx = '0;
  logic [PHASEBITS-1:0] savedFreq = '0;

  // 0: always ready, 1: random ready, 2: hold ready low 20 cycles once
  int readyMode = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Ready driver
  initial begin : readyDriver
    int  bpCnt;
    bit  bpUsed;
    bpCnt  = 0;
    bpUsed = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0: resReady = 1'b1;
        1: resReady = ($urandom_range(0, 3) != 0);
        default: begin
          resReady = 1'b1;
          if (!bpUsed && resValid) begin
            if (bpCnt < 20) begin
              resReady = 1'b0;
              bpCnt++;
            end else begin
              bpUsed = 1'b1;
            end
          end
        end
      endcase
      if (readyMode != 2) begin
        bpCnt  = 0;
        bpUsed = 1'b0;
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (cyc == zeroAt) begin
      checkOutput("reset_freq", freqOut, 0);
      checkOutput("reset_phase_rst", phaseRst, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_valid", resValid, 0);
      checkOutput("reset_res_i", resI, 0);
      checkOutput("reset_res_q", resQ, 0);
      checkOutput("reset_idx", resIdx, 0);
      checkOutput("reset_done", done, 0);
    end
    if (rst) begin
      expQ.delete();
      zeroAt = cyc + 1;
      doneAt = -1;
      gapAt = -1;
      idleAt = -1;
      prevValid = 1'b0;
      prevAccept = 1'b0;
    end else begin
      if (done || cyc == doneAt) begin
        checkOutput("done_pulse", done, (cyc == doneAt) ? 1 : 0);
      end
      if (done) doneCount++;
      if (cyc == idleAt) begin
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", resValid, 0);
      end
      if (cyc == gapAt) checkOutput("result_gap", resValid, 0);
      if (phaseRst) begin
        phaseCount++;
        lastRstCyc = cyc;
      end
      if (resValid && !prevValid) begin
        if (expQ.size() == 0) checkOutput("unexpected_result", 1, 0);
        else checkOutput("latency", cyc - lastRstCyc, expQ[0].lat);
      end
      if (resValid && prevValid && !prevAccept) begin
        checkOutput("hold_res_i", resI, savedI);
        checkOutput("hold_res_q", resQ, savedQ);
        checkOutput("hold_idx", resIdx, savedIdx);
        checkOutput("hold_freq", freqOut, savedFreq);
      end
      if (resValid && !resReady) stallCount++;

      prevAccept = 1'b0;
      if (abortPulse) begin
        expQ.delete();
        idleAt = cyc + 1;
      end else if (resValid && resReady) begin
        prevAccept = 1'b1;
        acceptCount++;
        if (expQ.size() == 0) begin
          checkOutput("accept_without_expected", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("res_idx", resIdx, e.idx);
          checkOutput("res_freq", freqOut, e.freq);
          checkOutput("res_i", longint'($signed(resI)), e.sumI);
          checkOutput("res_q", longint'($signed(resQ)), e.sumQ);
          if (e.last) doneAt = cyc + 1;
          else gapAt = cyc + 1;
        end
      end else if (startPulse && !busy && nPoints == '0) begin
        doneAt = cyc + 1;
      end
      prevValid = resValid;
    end
    savedI = resI;
    savedQ = resQ;
    savedIdx = resIdx;
    savedFreq = freqOut;
  end

  // Issue one sweep: push the expected results, then pulse start
  task automatic applyStimulus(input int n, input logic [31:0] fs, input logic [31:0] fst,
                               input int settle, input int avg, input longint dI, input longint dQ);
    exp_t e;
    logic [31:0] f;
    longint samples;
    longint settleLen;
    samples   = (avg == 0) ? 1 : avg;
    settleLen = (settle < 3) ? 3 : settle;
    f = fs;
    for (int k = 0; k < n; k++) begin
      e.idx  = k;
      e.freq = f;
      e.sumI = dI * samples;
      e.sumQ = dQ * samples;
      e.last = (k == n - 1);
      e.lat  = settleLen + samples + 1;
      expQ.push_back(e);
      f = f + fst;
    end
    @(posedge clk); #1;
    fStart       = fs;
    fStep        = fst;
    nPoints      = CNTBITS'(n);
    settleCycles = CNTBITS'(settle);
    avgCycles    = AVGBITS'(avg);
    demodI       = OUTBITS'(dI);
    demodQ       = OUTBITS'(dQ);
    startPulse   = 1'b1;
    @(posedge clk); #1;
    startPulse   = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((busy || expQ.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) checkOutput("sweep_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic waitPhaseCount(input int target, input int budget);
    int n;
    n = 0;
    while (phaseCount < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (phaseCount < target) checkOutput("phase_wait_timeout", phaseCount, target);
  endtask

  function automatic longint randSample();
    return longint'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic randomSweep(input bit pokeMidSweep);
    int n;
    int baseDone;
    n = $urandom_range(1, 4);
    baseDone = doneCount;
    applyStimulus(n, $urandom, $urandom, $urandom_range(0, 12), $urandom_range(0, 20),
                  randSample(), randSample());
    if (pokeMidSweep) begin
      // A second start and config changes while busy must be ignored
      repeat (3) @(posedge clk);
      #1;
      fStart       = $urandom;
      fStep        = $urandom;
      nPoints      = CNTBITS'($urandom_range(5, 9));
      settleCycles = CNTBITS'($urandom_range(0, 12));
      avgCycles    = AVGBITS'($urandom_range(0, 20));
      startPulse   = 1'b1;
      @(posedge clk); #1;
      startPulse   = 1'b0;
    end
    waitIdle(3000);
    checkOutput("random_done_count", doneCount - baseDone, 1);
  endtask

  initial begin : stimulus
    int basePhase;
    int baseDone;
    int baseAccept;
    int baseStall;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic 4-point sweep");
    readyMode = 0;
    basePhase = phaseCount;
    baseDone  = doneCount;
    applyStimulus(4, 32'd1000, 32'd250, 10, 8, 5, -3);
    waitIdle(2000);
    checkOutput("basic_phase_rst_count", phaseCount - basePhase, 4);
    checkOutput("basic_done_count", doneCount - baseDone, 1);
    checkOutput("basic_freq_hold", freqOut, 1750);

    $display("[TB] backpressure");
    readyMode  = 2;
    baseAccept = acceptCount;
    baseStall  = stallCount;
    applyStimulus(1, 32'd77, 32'd1, 3, 4, -7, 9);
    waitIdle(2000);
    readyMode = 0;
    checkOutput("bp_stall_cycles", stallCount - baseStall, 20);
    checkOutput("bp_accepts", acceptCount - baseAccept, 1);

    $display("[TB] extremes");
    applyStimulus(1, 32'd5, 32'd0, 0, 65535, -131072, 131071);
    waitIdle(70000);
    applyStimulus(2, 32'd9, 32'd3, 1, 0, 12345, -54321);
    waitIdle(2000);

    $display("[TB] frequency wrap");
    applyStimulus(2, 32'hFFFF_FF00, 32'h0000_0200, 3, 2, 1, 1);
    waitIdle(2000);

    $display("[TB] empty sweep");
    baseDone = doneCount;
    applyStimulus(0, 32'd1, 32'd1, 3, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("empty_busy", busy, 0);
      checkOutput("empty_valid", resValid, 0);
      @(posedge clk); #1;
    end
    checkOutput("empty_done_count", doneCount - baseDone, 1);

    $display("[TB] abort during point 2");
    basePhase  = phaseCount;
    baseDone   = doneCount;
    baseAccept = acceptCount;
    applyStimulus(4, 32'd2000, 32'd100, 4, 10, 3, 4);
    waitPhaseCount(basePhase + 3, 500);
    repeat (6) @(posedge clk);
    #1;
    abortPulse = 1'b1;
    startPulse = 1'b1;
    @(posedge clk); #1;
    abortPulse = 1'b0;
    startPulse = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("abort_accepts", acceptCount - baseAccept, 2);
    checkOutput("abort_done_count", doneCount - baseDone, 0);
    checkOutput("abort_freq_hold", freqOut, 2200);
    randomSweep(1'b0);

    $display("[TB] reset during point 2");
    basePhase  = phaseCount;
    baseDone   = doneCount;
    baseAccept = acceptCount;
    applyStimulus(4, 32'd3000, 32'd10, 5, 10, -2, 6);
    waitPhaseCount(basePhase + 3, 500);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("reset_accepts", acceptCount - baseAccept, 2);
    checkOutput("reset_done_count", doneCount - baseDone, 0);
    randomSweep(1'b0);

    $display("[TB] randomized sweeps");
    readyMode = 1;
    for (int s = 0; s < 4; s++) begin
      randomSweep(s[0]);
    end
    readyMode = 0;

    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
